// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host-to-device transmitter.
//   ps2_state_e  : transmitter FSM states
//   *_DEF        : default cycle counts for a 25 MHz clk
//   odd_parity() : parity bit that makes the 9-bit data+parity word odd
package ps2_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StRts,
        StShift,
        StWaitIdle,
        StFail
    } ps2_state_e;

    localparam int unsigned INHIBIT_CYC_DEF   = 2500;    // 100 us
    localparam int unsigned START_TMO_CYC_DEF = 375000;  // 15 ms
    localparam int unsigned FRAME_TMO_CYC_DEF = 50000;   // 2 ms
    localparam int unsigned FILT_CYC_DEF      = 8;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// CPU-side command interface of the PS/2 transmitter.
//   start     : one-cycle send request (honoured only while rdy=1)
//   data      : command byte, latched on an accepted start
//   rdy       : transmitter idle
//   done      : one-cycle end-of-frame pulse (success or error)
//   err       : sticky error flag, cleared by the next accepted start
//   tx_active : frame in flight; the PS/2 receiver ignores the lines while set
interface ps2_host_tx_if;
    logic       start;
    logic [7:0] data;
    logic       rdy;
    logic       done;
    logic       err;
    logic       tx_active;

    modport master (
        output start, data,
        input  rdy, done, err, tx_active
    );

    modport slave (
        input  start, data,
        output rdy, done, err, tx_active
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Conditioning for one raw PS/2 line: 2-FF synchronizer followed by a glitch
// filter that only follows the line after FILT_CYC consecutive samples that
// differ from the current filtered level.
//   clk, rst : clock, synchronous active-low reset
//   raw      : asynchronous pin value
//   filt     : filtered level (resets to 1, the idle level)
//   fall     : one-cycle pulse in the cycle filt first reads 0 after a 1
module ps2_line_filter #(
    parameter int unsigned FILT_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt,
    output logic fall
);

    localparam int unsigned FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [FW-1:0] CntLast = FW'(FILT_CYC - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, fall_q;
    logic [FW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            fall_q  <= 1'b0;
            if (sync2_q == filt_q) begin
                // Any agreeing sample restarts the run.
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                filt_q <= sync2_q;
                fall_q <= filt_q;  // old level 1 means this is a 1->0 change
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign filt = filt_q;
    assign fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Runs inhibit -> request-to-send -> bit
// shift on device clock falls -> ack sample -> wait for idle lines, with
// start and frame timeouts. Lines are open-drain: *_oe=1 pulls the pin low.
//   clk, rst         : clock, synchronous active-low reset
//   bus              : CPU command interface (slave side)
//   ps2c_i, ps2d_i   : raw clock / data pin values
//   ps2c_oe, ps2d_oe : pull-low enables for clock / data
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC   = INHIBIT_CYC_DEF,
    parameter int unsigned START_TMO_CYC = START_TMO_CYC_DEF,
    parameter int unsigned FRAME_TMO_CYC = FRAME_TMO_CYC_DEF,
    parameter int unsigned FILT_CYC      = FILT_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2c_i,
    input  logic          ps2d_i,
    output logic          ps2c_oe,
    output logic          ps2d_oe
);

    localparam int unsigned TmoMax =
        (START_TMO_CYC > FRAME_TMO_CYC) ? START_TMO_CYC : FRAME_TMO_CYC;
    // Timeouts fire before the counter could wrap.
    localparam int unsigned CntW = $clog2(TmoMax);

    localparam logic [CntW-1:0] InhLast   = CntW'(INHIBIT_CYC - 1);
    localparam logic [CntW-1:0] StartLast = CntW'(START_TMO_CYC - 1);
    localparam logic [CntW-1:0] FrameLast = CntW'(FRAME_TMO_CYC - 1);

    ps2_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      bitn_q;
    logic [7:0]      byte_q;
    logic            par_q;
    logic            rdy_q, done_q, err_q, tx_active_q;
    logic            c_oe_q, d_oe_q;

    logic c_filt, c_fall, d_filt, d_fall_unused;
    logic tmo;

    ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_filt_c (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2c_i),
        .filt (c_filt),
        .fall (c_fall)
    );

    ps2_line_filter #(.FILT_CYC(FILT_CYC)) u_filt_d (
        .clk  (clk),
        .rst  (rst),
        .raw  (ps2d_i),
        .filt (d_filt),
        .fall (d_fall_unused)
    );

    // A fall in the same cycle as the start timeout still wins the race.
    always_comb begin
        tmo = 1'b0;
        if (state_q == StRts) begin
            tmo = !c_fall && (cnt_q == StartLast);
        end else if (state_q == StShift || state_q == StWaitIdle) begin
            tmo = (cnt_q == FrameLast);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bitn_q      <= '0;
            byte_q      <= '0;
            par_q       <= 1'b0;
            rdy_q       <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tx_active_q <= 1'b0;
            c_oe_q      <= 1'b0;
            d_oe_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tmo) begin
                // Release, flag and finish at the edge entering StFail.
                state_q     <= StFail;
                c_oe_q      <= 1'b0;
                d_oe_q      <= 1'b0;
                err_q       <= 1'b1;
                done_q      <= 1'b1;
                tx_active_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // rdy stays low in the first idle cycle after done.
                        rdy_q <= 1'b1;
                        if (bus.start && rdy_q) begin
                            byte_q      <= bus.data;
                            par_q       <= odd_parity(bus.data);
                            err_q       <= 1'b0;
                            cnt_q       <= '0;
                            tx_active_q <= 1'b1;
                            rdy_q       <= 1'b0;
                            c_oe_q      <= 1'b1;
                            d_oe_q      <= 1'b0;
                            state_q     <= StInhibit;
                        end
                    end
                    StInhibit: begin
                        if (cnt_q == InhLast) begin
                            c_oe_q  <= 1'b0;
                            d_oe_q  <= 1'b1;  // start bit
                            cnt_q   <= '0;
                            state_q <= StRts;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StRts: begin
                        if (c_fall) begin
                            bitn_q  <= 4'd1;
                            d_oe_q  <= ~byte_q[0];
                            cnt_q   <= '0;
                            state_q <= StShift;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StShift: begin
                        cnt_q <= cnt_q + 1'b1;
                        if (c_fall) begin
                            // bitn_q holds the falls seen so far; act for the next.
                            bitn_q <= bitn_q + 1'b1;
                            case (bitn_q)
                                4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                                    d_oe_q <= ~byte_q[bitn_q[2:0]];
                                4'd8:    d_oe_q <= ~par_q;
                                4'd9:    d_oe_q <= 1'b0;
                                4'd10: begin
                                    err_q   <= d_filt;  // device ack pulls data low
                                    state_q <= StWaitIdle;
                                end
                                default: ;
                            endcase
                        end
                    end
                    StWaitIdle: begin
                        c_oe_q <= 1'b0;
                        d_oe_q <= 1'b0;
                        if (c_filt && d_filt) begin
                            done_q      <= 1'b1;
                            tx_active_q <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StFail: begin
                        rdy_q   <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.tx_active = tx_active_q;
    assign ps2c_oe       = c_oe_q;
    assign ps2d_oe       = d_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with scaled-down timing and an open-drain device model.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 50;
    localparam int unsigned STMO = 600;
    localparam int unsigned FTMO = 1500;
    localparam int unsigned FILT = 8;
    localparam int unsigned HALF = 20;  // device clock half period in clk cycles

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    logic ps2c_oe, ps2d_oe;
    logic dev_c_low = 1'b0;
    logic dev_d_low = 1'b0;
    logic ps2c_line, ps2d_line;

    // Wired-AND bus: either side pulling low wins.
    assign ps2c_line = !(ps2c_oe || dev_c_low);
    assign ps2d_line = !(ps2d_oe || dev_d_low);

    ps2_host_tx #(
        .INHIBIT_CYC   (INH),
        .START_TMO_CYC (STMO),
        .FRAME_TMO_CYC (FTMO),
        .FILT_CYC      (FILT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ps2c_i  (ps2c_line),
        .ps2d_i  (ps2d_line),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic err_at_done = 1'b0;
    logic tx_at_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clk and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.done) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc;
            err_at_done = bus.err;
            tx_at_done  = bus.tx_active;
        end
    endtask

    // Expected wire bits at device rising edges 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] ref_bits(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b};
    endfunction

    task automatic begin_frame(input logic [7:0] b, output int start_cyc, output int rts_cyc);
        int n;
        n = 0;
        while (!bus.rdy && n < 50) begin
            step();
            n++;
        end
        check_eq("rdy_before_start", bus.rdy, 1'b1);
        done_cnt   = 0;
        bus.data   = b;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        start_cyc  = cyc;
        check_eq("tx_active_on_start", bus.tx_active, 1'b1);
        n = 0;
        while (ps2c_oe && !ps2d_oe && n < INH + 20) begin
            n++;
            step();
        end
        check_eq("inhibit_len", n, INH);
        check_eq("rts_lines", {ps2c_oe, ps2d_oe}, 2'b01);
        rts_cyc = cyc;
    endtask

    // mode 0: plain, 1: clock glitch + ignored second start, 2: reset at bit 5
    task automatic device_frame(input logic [7:0] b, input bit ack, input int mode,
                                output logic [9:0] bits, output bit aborted);
        bits    = '0;
        aborted = 1'b0;
        repeat (30) step();
        for (int i = 1; i <= 11; i++) begin
            dev_c_low = 1'b1;
            for (int s = 0; s < int'(HALF); s++) begin
                step();
                if (mode == 2 && i == 5 && s == 12) begin
                    rst       = 1'b0;
                    bus.start = 1'b1;
                    bus.data  = 8'hA5;
                    step();
                    check_eq("rst_lines", {ps2c_oe, ps2d_oe}, 2'b00);
                    check_eq("rst_rdy", bus.rdy, 1'b1);
                    check_eq("rst_err", bus.err, 1'b0);
                    check_eq("rst_tx_active", bus.tx_active, 1'b0);
                    rst       = 1'b1;
                    bus.start = 1'b0;
                    dev_c_low = 1'b0;
                    step();
                    check_eq("rst_start_ignored", bus.tx_active, 1'b0);
                    aborted = 1'b1;
                    return;
                end
            end
            if (i <= 10) bits[i-1] = ps2d_line;
            dev_c_low = 1'b0;
            if (i == 10 && ack) dev_d_low = 1'b1;
            if (i == 11) dev_d_low = 1'b0;
            for (int s = 0; s < int'(HALF); s++) begin
                step();
                if (mode == 1 && i == 4 && s == 5) dev_c_low = 1'b1;
                if (mode == 1 && i == 4 && s == 8) dev_c_low = 1'b0;
                if (mode == 1 && i == 6 && s == 3) begin
                    bus.data  = ~b;
                    bus.start = 1'b1;
                end
                if (mode == 1 && i == 6 && s == 4) bus.start = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit ack, input int mode);
        int         sc, rc, n;
        logic [9:0] bits;
        bit         aborted;
        begin_frame(b, sc, rc);
        device_frame(b, ack, mode, bits, aborted);
        if (aborted) begin
            check_eq("rst_no_done", done_cnt, 0);
            return;
        end
        check_eq("wire_bits", bits, ref_bits(b));
        n = 0;
        while (done_cnt == 0 && n < 200) begin
            step();
            n++;
        end
        repeat (5) step();
        check_eq("done_once", done_cnt, 1);
        check_eq("err_at_done", err_at_done, !ack);
        check_eq("tx_off_at_done", tx_at_done, 1'b0);
        check_eq("lines_released", {ps2c_oe, ps2d_oe}, 2'b00);
        check_eq("err_sticky", bus.err, !ack);
        check_eq("rdy_after", bus.rdy, 1'b1);
    endtask

    task automatic run_timeout(input logic [7:0] b);
        int sc, rc, n;
        begin_frame(b, sc, rc);
        n = 0;
        while (done_cnt == 0 && n < int'(STMO) + 50) begin
            step();
            n++;
        end
        check_eq("tmo_from_rts", done_cyc - rc, STMO);
        check_eq("tmo_from_start", done_cyc - sc, INH + STMO);
        check_eq("tmo_err", err_at_done, 1'b1);
        check_eq("tmo_tx_off", tx_at_done, 1'b0);
        check_eq("tmo_lines", {ps2c_oe, ps2d_oe}, 2'b00);
        repeat (3) step();
        check_eq("tmo_done_once", done_cnt, 1);
        check_eq("tmo_rdy", bus.rdy, 1'b1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.data  = 8'h00;
        repeat (3) step();
        check_eq("reset_rdy", bus.rdy, 1'b1);
        check_eq("reset_done", bus.done, 1'b0);
        check_eq("reset_err", bus.err, 1'b0);
        check_eq("reset_tx_active", bus.tx_active, 1'b0);
        check_eq("reset_lines", {ps2c_oe, ps2d_oe}, 2'b00);
        rst = 1'b1;
        repeat (20) step();

        run_frame(8'hED, 1'b1, 0);
        run_frame(8'h00, 1'b1, 0);
        run_frame(8'h5A, 1'b0, 0);
        for (int k = 0; k < 4; k++) begin
            run_frame(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), 0);
        end
        run_frame(8'h3C, 1'b1, 1);
        run_timeout(8'hF4);
        run_frame(8'hC3, 1'b1, 2);
        repeat (20) step();
        run_frame(8'hFF, 1'b1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
